// File: rtl/main_control_fsm_pkg.sv
// rtl/main_control_fsm_pkg.sv - shared encodings for the multicycle main control FSM
package main_control_fsm_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_REG_B   = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       ior_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

    function automatic logic is_legal_opcode(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J);
    endfunction

endpackage

// File: rtl/main_control_outputs.sv
// rtl/main_control_outputs.sv - state to datapath control vector decode
module main_control_outputs
    import main_control_fsm_pkg::*;
(
    input  logic [3:0]        i_state,
    input  logic [5:0]        i_opcode,
    input  logic              i_mem_ready,
    output logic [CTRL_W-1:0] o_ctrl
);

    ctrl_t w_ctrl;

    always_comb begin
        w_ctrl = '0;
        case (i_state)
            S_FETCH: begin
                w_ctrl.mem_read  = 1'b1;
                w_ctrl.ir_write  = i_mem_ready;
                w_ctrl.pc_write  = i_mem_ready;
                w_ctrl.alu_src_b = SRCB_FOUR;
                w_ctrl.alu_op    = ALUOP_ADD;
                w_ctrl.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                w_ctrl.alu_src_b  = SRCB_IMM_SL2;
                w_ctrl.alu_op     = ALUOP_ADD;
                // An unrecognised opcode ends its instruction right here.
                w_ctrl.instr_done = !is_legal_opcode(i_opcode);
            end
            S_MEMADR: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = SRCB_IMM;
                w_ctrl.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                w_ctrl.mem_read = 1'b1;
                w_ctrl.ior_d    = 1'b1;
            end
            S_MEMWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.mem_to_reg = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                w_ctrl.mem_write  = 1'b1;
                w_ctrl.ior_d      = 1'b1;
                w_ctrl.instr_done = i_mem_ready;
            end
            S_EXEC: begin
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.reg_dst    = 1'b1;
                w_ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_ctrl.alu_src_a     = 1'b1;
                w_ctrl.alu_op        = ALUOP_SUB;
                w_ctrl.pc_write_cond = 1'b1;
                w_ctrl.pc_source     = PCSRC_ALUOUT;
                w_ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                w_ctrl.pc_write   = 1'b1;
                w_ctrl.pc_source  = PCSRC_JUMP;
                w_ctrl.instr_done = 1'b1;
            end
            default: w_ctrl = '0;
        endcase
    end

    assign o_ctrl = w_ctrl;

endmodule

// File: rtl/main_control_fsm.sv
// rtl/main_control_fsm.sv - multicycle processor main control FSM (state register and sequencing)
module main_control_fsm
    import main_control_fsm_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       memReady,
    output logic [1:0] aluOP,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSource,
    output logic       instrDone,
    output logic [3:0] state
);

    state_t            r_state;
    state_t            w_next;
    logic [CTRL_W-1:0] w_ctrl_vec;
    ctrl_t             w_ctrl;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = memReady ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_RTYPE:     w_next = S_EXEC;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_J:         w_next = S_JUMP;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  w_next = memReady ? S_MEMWB : S_MEMRD;
            S_MEMWR:  w_next = memReady ? S_FETCH : S_MEMWR;
            S_EXEC:   w_next = S_ALUWB;
            default:  w_next = S_FETCH;
        endcase
    end

    main_control_outputs u_outputs (
        .i_state     (r_state),
        .i_opcode    (opcode),
        .i_mem_ready (memReady),
        .o_ctrl      (w_ctrl_vec)
    );

    // Controls are held quiet for as long as reset is asserted, not just at the edge.
    assign w_ctrl = rst_n ? ctrl_t'(w_ctrl_vec) : '0;

    assign pcWrite     = w_ctrl.pc_write;
    assign pcWriteCond = w_ctrl.pc_write_cond;
    assign iorD        = w_ctrl.ior_d;
    assign memRead     = w_ctrl.mem_read;
    assign memWrite    = w_ctrl.mem_write;
    assign irWrite     = w_ctrl.ir_write;
    assign memToReg    = w_ctrl.mem_to_reg;
    assign regDst      = w_ctrl.reg_dst;
    assign regWrite    = w_ctrl.reg_write;
    assign aluSrcA     = w_ctrl.alu_src_a;
    assign aluOP       = w_ctrl.alu_op;
    assign aluSrcB     = w_ctrl.alu_src_b;
    assign pcSource    = w_ctrl.pc_source;
    assign instrDone   = w_ctrl.instr_done;
    assign state       = r_state;

endmodule

// File: tb/tb_main_control_fsm.sv
// tb/tb_main_control_fsm.sv - self-checking bench for main_control_fsm
module tb_main_control_fsm;
    import main_control_fsm_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic       memReady = 1'b0;
    logic [1:0] aluOP, aluSrcB, pcSource;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, instrDone;
    logic [3:0] state;

    int checks = 0;
    int failures = 0;

    state_t exp_path[$];
    int     obs_cycles, obs_done_cnt, obs_done_cycle;
    logic   obs_we, obs_regwrite;

    main_control_fsm dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .memReady(memReady),
        .aluOP(aluOP), .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite), .memToReg(memToReg),
        .regDst(regDst), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .pcSource(pcSource), .instrDone(instrDone), .state(state)
    );

    always #5 clk = ~clk;

    function automatic logic [16:0] obs_vec();
        return {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
                regDst, regWrite, aluSrcA, aluOP, aluSrcB, pcSource, instrDone};
    endfunction

    // Control table for each phase; instrDone is high when the final phase completes.
    function automatic logic [16:0] exp_vec(input state_t s, input logic mr, input logic last);
        logic pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, done;
        logic [1:0] aop, asb, psrc;
        {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, done} = '0;
        aop = 2'b00; asb = 2'b00; psrc = 2'b00;
        case (s)
            S_FETCH:  begin mrd = 1; irw = mr; pcw = mr; asb = 2'b01; end
            S_DECODE: asb = 2'b11;
            S_MEMADR: begin asa = 1; asb = 2'b10; end
            S_MEMRD:  begin mrd = 1; iod = 1; end
            S_MEMWB:  begin rw = 1; m2r = 1; end
            S_MEMWR:  begin mwr = 1; iod = 1; end
            S_EXEC:   begin asa = 1; aop = 2'b10; end
            S_ALUWB:  begin rw = 1; rdst = 1; end
            S_BRANCH: begin asa = 1; aop = 2'b01; pcc = 1; psrc = 2'b01; end
            S_JUMP:   begin pcw = 1; psrc = 2'b10; end
            default:  ;
        endcase
        done = last && (!(s == S_FETCH || s == S_MEMRD || s == S_MEMWR) || mr);
        return {pcw, pcc, iod, mrd, mwr, irw, m2r, rdst, rw, asa, aop, asb, psrc, done};
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            OP_LW:           return 5;
            OP_SW, OP_RTYPE: return 4;
            OP_BEQ, OP_J:    return 3;
            default:         return 2;
        endcase
    endfunction

    task automatic build_path(input logic [5:0] op);
        exp_path = {S_FETCH, S_DECODE};
        case (op)
            OP_LW:    begin exp_path.push_back(S_MEMADR); exp_path.push_back(S_MEMRD); exp_path.push_back(S_MEMWB); end
            OP_SW:    begin exp_path.push_back(S_MEMADR); exp_path.push_back(S_MEMWR); end
            OP_RTYPE: begin exp_path.push_back(S_EXEC); exp_path.push_back(S_ALUWB); end
            OP_BEQ:   exp_path.push_back(S_BRANCH);
            OP_J:     exp_path.push_back(S_JUMP);
            default:  ;
        endcase
    endtask

    task automatic step(input logic mr);
        state_t s;
        logic [16:0] e, o;
        @(negedge clk);
        memReady = mr;
        #1;
        s = exp_path[0];
        e = exp_vec(s, mr, exp_path.size() == 1);
        o = obs_vec();
        obs_cycles++;
        checks++;
        if (state !== s) begin
            failures++;
            $display("FAIL state @%0t: got %0d want %0d", $time, state, s);
        end
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL controls @%0t state %0d mr %0b: got %h want %h", $time, s, mr, o, e);
        end
        checks++;
        if ((memRead & memWrite) !== 1'b0) begin
            failures++;
            $display("FAIL mem_exclusive @%0t: got rd=%b wr=%b want not both", $time, memRead, memWrite);
        end
        checks++;
        if (aluOP === 2'b11) begin
            failures++;
            $display("FAIL aluop_legal @%0t: got %b want != 11", $time, aluOP);
        end
        checks++;
        if (!(state <= 4'd9)) begin
            failures++;
            $display("FAIL state_legal @%0t: got %0d want <= 9", $time, state);
        end
        if (instrDone === 1'b1) begin
            obs_done_cnt++;
            if (obs_done_cycle == 0) obs_done_cycle = obs_cycles;
        end
        if (s != S_FETCH && (pcWrite | pcWriteCond | memWrite | regWrite | irWrite)) obs_we = 1'b1;
        if (regWrite === 1'b1) obs_regwrite = 1'b1;
        @(posedge clk);
        #1;
        if (!(s == S_FETCH || s == S_MEMRD || s == S_MEMWR) || mr) void'(exp_path.pop_front());
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw);
        int fc = 0, mc = 0, lat;
        logic mr;
        opcode = op;
        build_path(op);
        obs_cycles = 0; obs_done_cnt = 0; obs_done_cycle = 0;
        obs_we = 1'b0; obs_regwrite = 1'b0;
        while (exp_path.size() > 0) begin
            mr = 1'b1;
            if (exp_path[0] == S_FETCH && fc < fw) begin mr = 1'b0; fc++; end
            else if ((exp_path[0] == S_MEMRD || exp_path[0] == S_MEMWR) && mc < mw) begin mr = 1'b0; mc++; end
            step(mr);
        end
        lat = latency(op) + fw + ((op == OP_LW || op == OP_SW) ? mw : 0);
        checks++;
        if (obs_done_cnt != 1) begin
            failures++;
            $display("FAIL done_count op %b: got %0d want 1", op, obs_done_cnt);
        end
        checks++;
        if (obs_done_cycle != lat) begin
            failures++;
            $display("FAIL done_cycle op %b: got %0d want %0d", op, obs_done_cycle, lat);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        memReady = 1'b1;
        opcode = OP_LW;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (state !== S_FETCH) begin
            failures++;
            $display("FAIL reset_state: got %0d want %0d", state, S_FETCH);
        end
        checks++;
        if (obs_vec() !== 17'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== exp_vec(S_FETCH, 1'b1, 1'b0)) begin
            failures++;
            $display("FAIL release_fetch: got %h want %h", obs_vec(), exp_vec(S_FETCH, 1'b1, 1'b0));
        end
    endtask

    task automatic test_lw();
        run_instr(OP_LW, 0, 0);
    endtask

    task automatic test_sw_wait();
        run_instr(OP_SW, 0, 3);
        checks++;
        if (obs_regwrite !== 1'b0) begin
            failures++;
            $display("FAIL sw_regwrite: got %b want 0", obs_regwrite);
        end
    endtask

    task automatic test_back_to_back();
        int total;
        run_instr(OP_RTYPE, 0, 0);
        total = obs_done_cycle;
        run_instr(OP_BEQ, 0, 0);
        total += obs_done_cycle;
        checks++;
        if (total != 7) begin
            failures++;
            $display("FAIL back_to_back_cycles: got %0d want 7", total);
        end
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 0, 0);
        checks++;
        if (obs_we !== 1'b0) begin
            failures++;
            $display("FAIL illegal_no_write: got %b want 0", obs_we);
        end
    endtask

    task automatic test_reset_mid_memrd();
        opcode = OP_LW;
        build_path(OP_LW);
        repeat (3) step(1'b1);
        @(negedge clk);
        memReady = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== S_MEMRD || obs_vec() !== 17'd0) begin
            failures++;
            $display("FAIL reset_in_memrd: got state %0d ctrl %h want state %0d ctrl 0", state, obs_vec(), S_MEMRD);
        end
        @(posedge clk);
        #1;
        checks++;
        if (state !== S_FETCH || obs_vec() !== 17'd0) begin
            failures++;
            $display("FAIL reset_edge: got state %0d ctrl %h want state 0 ctrl 0", state, obs_vec());
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs_vec() !== exp_vec(S_FETCH, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL post_reset_fetch: got %h want %h", obs_vec(), exp_vec(S_FETCH, 1'b0, 1'b0));
        end
        exp_path.delete();
        run_instr(OP_J, 1, 0);
    endtask

    task automatic test_random();
        logic [5:0] legal_ops [5] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J};
        logic [5:0] op;
        int total = 0;
        while (total < 10000) begin
            if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 4)];
            else op = 6'($urandom_range(0, 63));
            run_instr(op, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));
            total += obs_cycles;
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_back_to_back();
        test_illegal();
        test_reset_mid_memrd();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 SHALL have no parameters; all encodings come from the shared package.
REQ-002 clk  in  1  sole clock; all state changes on the rising edge.
REQ-003 rst_n  in  1  synchronous, active-low reset.
REQ-004 opcode  in  6  instruction[31:26], valid from the DECODE state onward.
REQ-005 memReady  in  1  memory handshake; 1 = current access completes this cycle.
REQ-006 aluOP  out  2  to ALU control: 00 = add, 01 = subtract, 10 = use the funct field.
REQ-007 pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg, regDst, regWrite, aluSrcA  out  1 each  multicycle datapath controls.
REQ-008 aluSrcB  out  2  00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = immediate shifted left by 2.
REQ-009 pcSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-010 instrDone  out  1  one-cycle pulse in the final state of each instruction.
REQ-011 state  out  4  current state, for debug.

Function
REQ-012 SHALL be a Moore FSM; outputs SHALL decode from the state register only (plus the memReady gating in REQ-014).
REQ-013 States and transitions:
- FETCH -> DECODE.
- DECODE -> MEMADR for lw/sw; EXEC for R-type; BRANCH for beq; JUMP for j.
- MEMADR -> MEMRD for lw; MEMWR for sw.
- MEMRD -> MEMWB.
- EXEC -> ALUWB.
- MEMWB, MEMWR, ALUWB, BRANCH, JUMP -> FETCH.
REQ-014 FETCH, MEMRD and MEMWR SHALL hold while memReady = 0. In these states pcWrite, irWrite and instrDone SHALL be asserted only in the cycle where memReady = 1. memRead/memWrite SHALL stay high for the whole wait.
REQ-015 Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010.
REQ-016 Any other opcode in DECODE SHALL return to FETCH, pulse instrDone and change no architectural state (no write enables asserted).
REQ-017 Output values per state (any control not listed is 0):
- FETCH: memRead = 1, irWrite = 1, aluSrcB = 01, aluOP = 00, pcWrite = 1, pcSource = 00.
- DECODE: aluSrcB = 11, aluOP = 00.
- MEMADR: aluSrcA = 1, aluSrcB = 10, aluOP = 00.
- MEMRD: memRead = 1, iorD = 1.
- MEMWB: regWrite = 1, memToReg = 1.
- MEMWR: memWrite = 1, iorD = 1.
- EXEC: aluSrcA = 1, aluOP = 10.
- ALUWB: regWrite = 1, regDst = 1.
- BRANCH: aluSrcA = 1, aluOP = 01, pcWriteCond = 1, pcSource = 01.
- JUMP: pcWrite = 1, pcSource = 10.
REQ-018 Latency with memReady held at 1: lw 5 cycles, sw 4, R-type 4, beq 3, j 3, illegal opcode 2. instrDone SHALL fire in the last cycle.
REQ-019 memRead and memWrite SHALL never be high in the same cycle.
REQ-020 Unused state encodings SHALL go to FETCH on the next edge, with all outputs 0 while in them.

Reset
REQ-021 With rst_n = 0 at a rising edge, state SHALL become FETCH, overriding any in-flight instruction or memory wait.
REQ-022 While rst_n = 0, every control output and instrDone SHALL be forced to 0; state SHALL read FETCH after the first reset edge.
REQ-023 On the first edge with rst_n = 1, FETCH outputs SHALL take effect.

Structure
REQ-024 The shared package SHALL hold: state encodings (4-bit), the opcode constants, the aluOP constants (ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT), and the aluSrcB and pcSource encodings.
REQ-025 One combinational sub-module, main_control_outputs (state -> control vector), SHALL be instantiated; next-state logic and the state register SHALL stay in main_control_fsm.

Verification
REQ-026 lw: reset, then opcode = 100011, memReady = 1 -> states FETCH, DECODE, MEMADR, MEMRD, MEMWB; regWrite = memToReg = 1 only in cycle 5; instrDone in cycle 5.
REQ-027 sw with memReady = 0 for 3 cycles in MEMWR -> MEMWR held 4 cycles with memWrite = 1 throughout; instrDone only in the memReady = 1 cycle; regWrite stays 0.
REQ-028 R-type then beq back-to-back -> aluOP = 10 in EXEC, regDst = regWrite = 1 in ALUWB; aluOP = 01 and pcWriteCond = 1 in BRANCH; 7 cycles total.
REQ-029 Opcode 111111 -> FETCH, DECODE, FETCH; no write enable asserted; instrDone pulses in DECODE.
REQ-030 rst_n = 0 for one edge while in MEMRD -> state = FETCH and all outputs 0 during reset; FETCH outputs on the following cycle.
REQ-031 Assertions over a random opcode/memReady stream of at least 10k cycles: no cycle with memRead & memWrite; aluOP never 11; state always legal.
